// File: rtl/div_rem_sched_if.sv
// Core-side request/response bundle for the divide/remainder scheduler.
// The cores drive the master side and the scheduler sits on the slave side.
interface div_rem_sched_if;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/div_rem_sched.sv
// Four-core divide/remainder scheduler: round-robin accept, operand normalisation,
// special-case bypass and result retirement. `DIV_FASTPATH_EN` bypasses |a|<|b|.
module div_rem_sched (
    input  logic                 clk,
    input  logic                 reset,
    div_rem_sched_if.slave       bus,
    output logic                 iss_request,
    output logic                 iss_sign_state,
    output logic                 iss_rem_or_div,
    output logic [2:0]           iss_core_num,
    output logic [4:0]           iss_shift_stack,
    output logic [4:0]           iss_shift_save,
    output logic [31:0]          iss_dividend,
    output logic [31:0]          iss_divisor,
    input  logic                 ret_ready,
    input  logic                 ret_sign_state,
    input  logic                 ret_rem_or_div,
    input  logic [2:0]           ret_core_num,
    input  logic [31:0]          ret_dividend,
    input  logic [31:0]          ret_quotient
);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    logic [3:0]  busy_q, busy_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        byp_pend_q, byp_pend_d;
    logic [1:0]  byp_core_q, byp_core_d;
    logic [31:0] byp_data_q, byp_data_d;
    logic [3:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        iss_request_q, iss_request_d;
    logic        iss_sign_state_q, iss_sign_state_d;
    logic        iss_rem_or_div_q, iss_rem_or_div_d;
    logic [2:0]  iss_core_num_q, iss_core_num_d;
    logic [4:0]  iss_shift_q, iss_shift_d;
    logic [31:0] iss_dividend_q, iss_dividend_d;
    logic [31:0] iss_divisor_q, iss_divisor_d;

    logic [3:0]  eligible;
    logic [3:0]  grant_oh;
    logic        grant_found;
    logic [1:0]  grant_idx;

    // Held bypass blocks all grants so it can never collide with a second one.
    assign eligible = bus.req_valid & ~busy_q & {4{~byp_pend_q & reset}};

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        grant_oh    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < 4; k++) begin
            if (!grant_found && eligible[ptr_q + 2'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = ptr_q + 2'(k);
            end
        end
        if (grant_found) grant_oh[grant_idx] = 1'b1;
    end

    op_e         op_sel;
    logic [31:0] a_sel, b_sel, abs_a, abs_b;
    logic        is_signed, is_rem, sign_sel;
    logic [5:0]  clz_a, clz_b;
    logic [4:0]  shift;
    logic        is_zero, is_ovf, is_fast, is_byp;
    logic [31:0] byp_val;

    assign op_sel    = op_e'(bus.req_op[{grant_idx, 1'b0} +: 2]);
    assign a_sel     = bus.req_a[{grant_idx, 5'b0} +: 32];
    assign b_sel     = bus.req_b[{grant_idx, 5'b0} +: 32];
    assign is_signed = (op_sel == OP_DIV) || (op_sel == OP_REM);
    assign is_rem    = (op_sel == OP_REM) || (op_sel == OP_REMU);
    assign abs_a     = (is_signed && a_sel[31]) ? (~a_sel + 32'd1) : a_sel;
    assign abs_b     = (is_signed && b_sel[31]) ? (~b_sel + 32'd1) : b_sel;
    assign sign_sel  = is_signed && (is_rem ? a_sel[31] : (a_sel[31] ^ b_sel[31]));
    assign clz_a     = clz32(abs_a);
    assign clz_b     = clz32(abs_b);
    // Divisor is left-aligned with the dividend; a smaller dividend gets no shift.
    assign shift     = (clz_b > clz_a) ? 5'(clz_b - clz_a) : 5'd0;
    assign is_zero   = (b_sel == 32'd0);
    assign is_ovf    = is_signed && (a_sel == 32'h8000_0000) && (b_sel == 32'hFFFF_FFFF);
`ifdef DIV_FASTPATH_EN
    assign is_fast   = (abs_a < abs_b);
`else
    assign is_fast   = 1'b0;
`endif
    assign is_byp    = is_zero || is_ovf || is_fast;

    always_comb begin
        byp_val = is_rem ? a_sel : 32'd0;
        if (is_zero)     byp_val = is_rem ? a_sel : 32'hFFFF_FFFF;
        else if (is_ovf) byp_val = is_rem ? 32'd0 : 32'h8000_0000;
    end

    logic        ret_hit;
    logic [1:0]  ret_idx;
    logic [31:0] ret_sel, ret_val;

    assign ret_idx = ret_core_num[1:0];
    assign ret_hit = ret_ready && !ret_core_num[2] && busy_q[ret_idx]
                     && !(byp_pend_q && (byp_core_q == ret_idx));
    assign ret_sel = ret_rem_or_div ? ret_dividend : ret_quotient;
    assign ret_val = ret_sign_state ? (~ret_sel + 32'd1) : ret_sel;

    always_comb begin
        busy_d           = busy_q;
        ptr_d            = ptr_q;
        byp_pend_d       = byp_pend_q;
        byp_core_d       = byp_core_q;
        byp_data_d       = byp_data_q;
        rsp_valid_d      = '0;
        rsp_data_d       = rsp_data_q;
        iss_request_d    = 1'b0;
        iss_sign_state_d = iss_sign_state_q;
        iss_rem_or_div_d = iss_rem_or_div_q;
        iss_core_num_d   = iss_core_num_q;
        iss_shift_d      = iss_shift_q;
        iss_dividend_d   = iss_dividend_q;
        iss_divisor_d    = iss_divisor_q;

        // Retire owns the response port; a held bypass drains on the first free cycle.
        if (ret_hit) begin
            rsp_valid_d[ret_idx] = 1'b1;
            rsp_data_d           = ret_val;
            busy_d[ret_idx]      = 1'b0;
        end else if (byp_pend_q) begin
            rsp_valid_d[byp_core_q] = 1'b1;
            rsp_data_d              = byp_data_q;
            busy_d[byp_core_q]      = 1'b0;
            byp_pend_d              = 1'b0;
        end

        if (grant_found) begin
            ptr_d = grant_idx + 2'd1;
            if (is_byp) begin
                if (ret_hit) begin
                    byp_pend_d        = 1'b1;
                    byp_core_d        = grant_idx;
                    byp_data_d        = byp_val;
                    busy_d[grant_idx] = 1'b1;
                end else begin
                    rsp_valid_d[grant_idx] = 1'b1;
                    rsp_data_d             = byp_val;
                end
            end else begin
                busy_d[grant_idx] = 1'b1;
                iss_request_d     = 1'b1;
                iss_sign_state_d  = sign_sel;
                iss_rem_or_div_d  = is_rem;
                iss_core_num_d    = {1'b0, grant_idx};
                iss_shift_d       = shift;
                iss_dividend_d    = abs_a;
                iss_divisor_d     = abs_b << shift;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q           <= '0;
            ptr_q            <= '0;
            byp_pend_q       <= 1'b0;
            byp_core_q       <= '0;
            byp_data_q       <= '0;
            rsp_valid_q      <= '0;
            rsp_data_q       <= '0;
            iss_request_q    <= 1'b0;
            iss_sign_state_q <= 1'b0;
            iss_rem_or_div_q <= 1'b0;
            iss_core_num_q   <= '0;
            iss_shift_q      <= '0;
            iss_dividend_q   <= '0;
            iss_divisor_q    <= '0;
        end else begin
            busy_q           <= busy_d;
            ptr_q            <= ptr_d;
            byp_pend_q       <= byp_pend_d;
            byp_core_q       <= byp_core_d;
            byp_data_q       <= byp_data_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            iss_request_q    <= iss_request_d;
            iss_sign_state_q <= iss_sign_state_d;
            iss_rem_or_div_q <= iss_rem_or_div_d;
            iss_core_num_q   <= iss_core_num_d;
            iss_shift_q      <= iss_shift_d;
            iss_dividend_q   <= iss_dividend_d;
            iss_divisor_q    <= iss_divisor_d;
        end
    end

    assign bus.req_ready    = grant_oh;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign iss_request      = iss_request_q;
    assign iss_sign_state   = iss_sign_state_q;
    assign iss_rem_or_div   = iss_rem_or_div_q;
    assign iss_core_num     = iss_core_num_q;
    assign iss_shift_stack  = iss_shift_q;
    assign iss_shift_save   = iss_shift_q;
    assign iss_dividend     = iss_dividend_q;
    assign iss_divisor      = iss_divisor_q;

endmodule

// File: tb/tb_div_rem_sched.sv
// Directed self-checking bench for div_rem_sched; the bench plays the four cores
// and the divider pipeline tail, with hand-computed expected values.
module tb_div_rem_sched;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iss_request, iss_sign_state, iss_rem_or_div;
    logic [2:0]  iss_core_num;
    logic [4:0]  iss_shift_stack, iss_shift_save;
    logic [31:0] iss_dividend, iss_divisor;
    logic        ret_ready, ret_sign_state, ret_rem_or_div;
    logic [2:0]  ret_core_num;
    logic [31:0] ret_dividend, ret_quotient;

    int total = 0;
    int bad   = 0;

    div_rem_sched_if bus_if ();

    div_rem_sched dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_if),
        .iss_request     (iss_request),
        .iss_sign_state  (iss_sign_state),
        .iss_rem_or_div  (iss_rem_or_div),
        .iss_core_num    (iss_core_num),
        .iss_shift_stack (iss_shift_stack),
        .iss_shift_save  (iss_shift_save),
        .iss_dividend    (iss_dividend),
        .iss_divisor     (iss_divisor),
        .ret_ready       (ret_ready),
        .ret_sign_state  (ret_sign_state),
        .ret_rem_or_div  (ret_rem_or_div),
        .ret_core_num    (ret_core_num),
        .ret_dividend    (ret_dividend),
        .ret_quotient    (ret_quotient)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.req_valid[c]       = 1'b1;
        bus_if.req_op[2*c +: 2]   = op;
        bus_if.req_a[32*c +: 32]  = a;
        bus_if.req_b[32*c +: 32]  = b;
    endtask

    task automatic set_ret(input logic [2:0] core, input logic sgn, input logic rem,
                           input logic [31:0] rmd, input logic [31:0] quo);
        ret_ready      = 1'b1;
        ret_core_num   = core;
        ret_sign_state = sgn;
        ret_rem_or_div = rem;
        ret_dividend   = rmd;
        ret_quotient   = quo;
    endtask

    task automatic clr_ret();
        ret_ready = 1'b0;
    endtask

    initial begin
        bus_if.req_valid = '0;
        bus_if.req_op    = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        ret_ready = 1'b0; ret_sign_state = 1'b0; ret_rem_or_div = 1'b0;
        ret_core_num = '0; ret_dividend = '0; ret_quotient = '0;

        // Reset state with every core requesting
        for (int c = 0; c < 4; c++) set_req(c, OP_DIVU, 32'd100, 32'd7);
        repeat (2) tick();
        check("rst_ready",     {28'd0, bus_if.req_ready}, 32'h0);
        check("rst_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h0);
        check("rst_rsp_data",  bus_if.rsp_data, 32'h0);
        check("rst_iss_req",   {31'd0, iss_request}, 32'h0);
        check("rst_iss_dvd",   iss_dividend, 32'h0);
        check("rst_iss_dvs",   iss_divisor, 32'h0);
        check("rst_iss_core",  {29'd0, iss_core_num}, 32'h0);
        check("rst_iss_shift", {27'd0, iss_shift_stack}, 32'h0);
        bus_if.req_valid = '0;
        reset = 1'b1;

        // Core0 DIVU 100/7: shift 4, divisor 112, quotient 14
        set_req(0, OP_DIVU, 32'd100, 32'd7);
        #1 check("divu_ready", {28'd0, bus_if.req_ready}, 32'h1);
        tick();
        bus_if.req_valid[0] = 1'b0;
        check("divu_iss_req",   {31'd0, iss_request}, 32'h1);
        check("divu_iss_core",  {29'd0, iss_core_num}, 32'h0);
        check("divu_shift_stk", {27'd0, iss_shift_stack}, 32'd4);
        check("divu_shift_sav", {27'd0, iss_shift_save}, 32'd4);
        check("divu_divisor",   iss_divisor, 32'd112);
        check("divu_dividend",  iss_dividend, 32'd100);
        check("divu_sign",      {31'd0, iss_sign_state}, 32'h0);
        check("divu_remsel",    {31'd0, iss_rem_or_div}, 32'h0);
        check("divu_no_rsp",    {28'd0, bus_if.rsp_valid}, 32'h0);
        tick();
        check("divu_iss_once",  {31'd0, iss_request}, 32'h0);
        set_ret(3'd0, 1'b0, 1'b0, 32'd2, 32'd14);
        tick();
        clr_ret();
        check("divu_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h1);
        check("divu_rsp_data",  bus_if.rsp_data, 32'd14);
        tick();
        check("divu_rsp_once",  {28'd0, bus_if.rsp_valid}, 32'h0);

        // Core2 REM/DIV -7 by 2
        set_req(2, OP_REM, 32'hFFFF_FFF9, 32'd2);
        #1 check("rem_ready", {28'd0, bus_if.req_ready}, 32'h4);
        tick();
        bus_if.req_valid[2] = 1'b0;
        check("rem_iss_core",  {29'd0, iss_core_num}, 32'd2);
        check("rem_sign",      {31'd0, iss_sign_state}, 32'h1);
        check("rem_remsel",    {31'd0, iss_rem_or_div}, 32'h1);
        check("rem_dividend",  iss_dividend, 32'd7);
        check("rem_divisor",   iss_divisor, 32'd4);
        check("rem_shift",     {27'd0, iss_shift_stack}, 32'd1);
        set_ret(3'd2, 1'b1, 1'b1, 32'd1, 32'd3);
        tick();
        clr_ret();
        check("rem_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h4);
        check("rem_rsp_data",  bus_if.rsp_data, 32'hFFFF_FFFF);
        set_req(2, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        bus_if.req_valid[2] = 1'b0;
        check("sdiv_sign",     {31'd0, iss_sign_state}, 32'h1);
        check("sdiv_remsel",   {31'd0, iss_rem_or_div}, 32'h0);
        set_ret(3'd2, 1'b1, 1'b0, 32'd1, 32'd3);
        tick();
        clr_ret();
        check("sdiv_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h4);
        check("sdiv_rsp_data",  bus_if.rsp_data, 32'hFFFF_FFFD);

        // Core1 bypass cases
        set_req(1, OP_DIV, 32'd5, 32'd0);
        #1 check("dz_ready", {28'd0, bus_if.req_ready}, 32'h2);
        tick();
        check("dz_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h2);
        check("dz_rsp_data",  bus_if.rsp_data, 32'hFFFF_FFFF);
        check("dz_no_issue",  {31'd0, iss_request}, 32'h0);
        set_req(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        check("ovf_div_valid", {28'd0, bus_if.rsp_valid}, 32'h2);
        check("ovf_div_data",  bus_if.rsp_data, 32'h8000_0000);
        set_req(1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        check("ovf_rem_data",  bus_if.rsp_data, 32'h0);
        set_req(1, OP_REMU, 32'h0000_1234, 32'd0);
        tick();
        check("remu_z_data",   bus_if.rsp_data, 32'h0000_1234);
        set_req(1, OP_REMU, 32'd3, 32'd10);
        tick();
        bus_if.req_valid[1] = 1'b0;
`ifdef DIV_FASTPATH_EN
        check("fast_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h2);
        check("fast_rsp_data",  bus_if.rsp_data, 32'd3);
        check("fast_no_issue",  {31'd0, iss_request}, 32'h0);
`else
        check("slow_iss_req",   {31'd0, iss_request}, 32'h1);
        check("slow_shift",     {27'd0, iss_shift_stack}, 32'd0);
        check("slow_divisor",   iss_divisor, 32'd10);
        check("slow_dividend",  iss_dividend, 32'd3);
        set_ret(3'd1, 1'b0, 1'b1, 32'd3, 32'd0);
        tick();
        clr_ret();
        check("slow_rsp_valid", {28'd0, bus_if.rsp_valid}, 32'h2);
        check("slow_rsp_data",  bus_if.rsp_data, 32'd3);
`endif
        tick();
        check("byp_quiet", {28'd0, bus_if.rsp_valid}, 32'h0);

        // Dropped retires: idle core, and out-of-range core number
        set_ret(3'd0, 1'b0, 1'b0, 32'd0, 32'd5);
        tick();
        clr_ret();
        check("ret_idle_drop", {28'd0, bus_if.rsp_valid}, 32'h0);
        set_req(0, OP_DIVU, 32'd100, 32'd7);
        tick();
        bus_if.req_valid[0] = 1'b0;
        set_ret(3'd4, 1'b0, 1'b0, 32'd2, 32'd14);
        tick();
        clr_ret();
        check("ret_core4_drop", {28'd0, bus_if.rsp_valid}, 32'h0);
        set_ret(3'd0, 1'b0, 1'b0, 32'd2, 32'd14);
        tick();
        clr_ret();
        check("ret_core0_ok", {28'd0, bus_if.rsp_valid}, 32'h1);

        // Round-robin from reset with all cores requesting
        reset = 1'b0;
        for (int c = 0; c < 4; c++) set_req(c, OP_DIVU, 32'd100, 32'd7);
        tick();
        reset = 1'b1;
        #1 check("rr_ready0", {28'd0, bus_if.req_ready}, 32'h1);
        tick();
        check("rr_core0",  {29'd0, iss_core_num}, 32'd0);
        check("rr_ready1", {28'd0, bus_if.req_ready}, 32'h2);
        tick();
        check("rr_core1",  {29'd0, iss_core_num}, 32'd1);
        check("rr_ready2", {28'd0, bus_if.req_ready}, 32'h4);
        tick();
        check("rr_core2",  {29'd0, iss_core_num}, 32'd2);
        check("rr_ready3", {28'd0, bus_if.req_ready}, 32'h8);
        tick();
        check("rr_core3",  {29'd0, iss_core_num}, 32'd3);
        check("rr_all_busy", {28'd0, bus_if.req_ready}, 32'h0);
        tick();
        check("rr_wait_req",  {31'd0, iss_request}, 32'h0);
        check("rr_wait_rdy",  {28'd0, bus_if.req_ready}, 32'h0);
        set_ret(3'd1, 1'b0, 1'b0, 32'd2, 32'd14);
        tick();
        clr_ret();
        check("rr_ret1_valid", {28'd0, bus_if.rsp_valid}, 32'h2);
        check("rr_reaccept1",  {28'd0, bus_if.req_ready}, 32'h2);
        tick();
        check("rr_reiss_req",  {31'd0, iss_request}, 32'h1);
        check("rr_reiss_core", {29'd0, iss_core_num}, 32'd1);

        // Reset with work in flight
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {28'd0, bus_if.req_ready}, 32'h0);
        check("mid_rst_rspv",  {28'd0, bus_if.rsp_valid}, 32'h0);
        check("mid_rst_rspd",  bus_if.rsp_data, 32'h0);
        check("mid_rst_iss",   {31'd0, iss_request}, 32'h0);
        check("mid_rst_dvs",   iss_divisor, 32'h0);
        bus_if.req_valid = '0;
        tick();
        reset = 1'b1;
        set_ret(3'd0, 1'b0, 1'b0, 32'd2, 32'd14);
        tick();
        check("post_rst_drop0", {28'd0, bus_if.rsp_valid}, 32'h0);
        set_ret(3'd2, 1'b0, 1'b0, 32'd2, 32'd14);
        tick();
        clr_ret();
        check("post_rst_drop2", {28'd0, bus_if.rsp_valid}, 32'h0);

        // Bypass accepted in the same cycle a retire arrives
        set_req(0, OP_DIVU, 32'd100, 32'd7);
        tick();
        bus_if.req_valid[0] = 1'b0;
        check("col_iss_core", {29'd0, iss_core_num}, 32'd0);
        set_ret(3'd0, 1'b0, 1'b0, 32'd2, 32'd14);
        set_req(1, OP_DIV, 32'd9, 32'd0);
        set_req(3, OP_DIVU, 32'd100, 32'd7);
        #1 check("col_ready_m", {28'd0, bus_if.req_ready}, 32'h2);
        tick();
        clr_ret();
        bus_if.req_valid[1] = 1'b0;
        check("col_ret_valid", {28'd0, bus_if.rsp_valid}, 32'h1);
        check("col_ret_data",  bus_if.rsp_data, 32'd14);
        check("col_no_grant",  {28'd0, bus_if.req_ready}, 32'h0);
        tick();
        check("col_byp_valid", {28'd0, bus_if.rsp_valid}, 32'h2);
        check("col_byp_data",  bus_if.rsp_data, 32'hFFFF_FFFF);
        check("col_grant3",    {28'd0, bus_if.req_ready}, 32'h8);
        tick();
        bus_if.req_valid[3] = 1'b0;
        check("col_iss3_req",  {31'd0, iss_request}, 32'h1);
        check("col_iss3_core", {29'd0, iss_core_num}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
